rsnn_cfg_loader: RTL and testbench

// - Parametrised serial configuration loader for the RSNN core: collects per-layer neuron

---
 rtl/rsnn_cfg_loader.sv | 226 ++++++++++++++++++++++
 tb/tb_rsnn_cfg_loader.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsnn_cfg_loader.sv
// rsnn_cfg_loader: serial configuration loader for the RSNN core.
// Collects neuron parameters and synaptic weights one bit at a time over a load strobe and
// a data pin, then presents them as a flat word-indexed configuration bus.
// Optional feature macro: CFG_READBACK_EN (serial readback of shifted-out bits on sdo_o).
module rsnn_cfg_loader #(
    parameter int unsigned N_LAYERS = 3,
    parameter int unsigned N_PARAM  = 4,
    parameter int unsigned N_WGT    = 9,
    parameter int unsigned WORD_W   = 8,
    parameter int unsigned MIN_HOLD = 3,
    localparam int unsigned N_WORDS = N_LAYERS * (N_PARAM + N_WGT),
    localparam int unsigned TOTAL   = N_WORDS * WORD_W,
    localparam int unsigned CW      = $clog2(TOTAL + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             load_i,
    input  logic             sdata_i,
    input  logic             run_i,
    output logic [TOTAL-1:0] cfg_o,
    output logic             cfg_valid_o,
    output logic [CW-1:0]    bit_cnt_o,
    output logic             err_ovf_o,
    output logic             sdo_o
);

    localparam int unsigned   HW        = $clog2(MIN_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(MIN_HOLD);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MIN_HOLD - 1);
    localparam logic [CW-1:0] TOTAL_CNT = CW'(TOTAL);
    localparam logic [CW-1:0] ONE_CNT   = CW'(1);

    // Reset release synchroniser: assertion is immediate, release is aligned to clk.
    logic [1:0] r_rst_sync;
    logic       w_rst_rel;

    // Pin synchronisers, bit order {run, sdata, load}.
    logic [2:0] r_pin_meta;
    logic [2:0] r_pin_sync;
    logic       w_load_s;
    logic       w_sdata_s;
    logic       w_run_s;

    // Strobe qualification.
    logic [HW-1:0] r_hold_cnt;
    logic [HW-1:0] w_hold_d;
    logic          r_qual;
    logic          w_qual_d;
    logic          r_bit;
    logic          w_bit_d;
    logic          w_commit;

    // Configuration shift register and session state.
    logic [TOTAL-1:0] r_cfg;
    logic [TOTAL-1:0] w_cfg_d;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_d;
    logic [CW-1:0]    w_cnt_inc;
    logic             r_valid;
    logic             w_valid_d;
    logic             r_ovf;
    logic             w_ovf_d;
    logic             r_armed;
    logic             w_armed_d;
    logic             w_shift;

    assign w_rst_rel = r_rst_sync[1];
    assign w_load_s  = r_pin_sync[0];
    assign w_sdata_s = r_pin_sync[1];
    assign w_run_s   = r_pin_sync[2];
    assign w_cnt_inc = r_cnt + 1'b1;

    // Two-stage reset release synchroniser.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    // Two-flop synchronisers for the asynchronous pins; they run regardless of ena.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pin_meta <= '0;
            r_pin_sync <= '0;
        end else if (!w_rst_rel) begin
            r_pin_meta <= '0;
            r_pin_sync <= '0;
        end else begin
            r_pin_meta <= {run_i, sdata_i, load_i};
            r_pin_sync <= r_pin_meta;
        end
    end

    // Hold counter: qualify a strobe once load_s has been high MIN_HOLD cycles, commit on fall.
    always_comb begin
        w_hold_d = r_hold_cnt;
        w_qual_d = r_qual;
        w_bit_d  = r_bit;
        w_commit = 1'b0;
        if (!ena) begin
            w_hold_d = '0;
            w_qual_d = 1'b0;
        end else if (w_load_s) begin
            if (r_hold_cnt != HOLD_MAX) begin
                w_hold_d = r_hold_cnt + 1'b1;
                if (r_hold_cnt == HOLD_LAST) begin
                    // Data is sampled exactly once per strobe, when it first qualifies.
                    w_bit_d  = w_sdata_s;
                    w_qual_d = 1'b1;
                end
            end
        end else begin
            w_hold_d = '0;
            w_qual_d = 1'b0;
            w_commit = r_qual;
        end
    end

    // Strobe qualification state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_cnt <= '0;
            r_qual     <= 1'b0;
            r_bit      <= 1'b0;
        end else if (!w_rst_rel) begin
            r_hold_cnt <= '0;
            r_qual     <= 1'b0;
            r_bit      <= 1'b0;
        end else begin
            r_hold_cnt <= w_hold_d;
            r_qual     <= w_qual_d;
            r_bit      <= w_bit_d;
        end
    end

    // Session next-state: run lockout and re-arm, new-session start, shift-in, overflow.
    always_comb begin
        w_cfg_d   = r_cfg;
        w_cnt_d   = r_cnt;
        w_valid_d = r_valid;
        w_ovf_d   = r_ovf;
        w_armed_d = r_armed;
        w_shift   = 1'b0;
        if (ena) begin
            if (w_run_s) begin
                // Run has priority over a coincident commit, which is dropped.
                if (r_cnt != '0) begin
                    w_armed_d = 1'b1;
                end
            end else if (w_commit) begin
                if (r_armed) begin
                    // First bit of a fresh session shifts into an all-zero register.
                    w_cfg_d            = '0;
                    w_cfg_d[TOTAL-1]   = r_bit;
                    w_cnt_d            = ONE_CNT;
                    w_valid_d          = (TOTAL_CNT == ONE_CNT);
                    w_ovf_d            = 1'b0;
                    w_armed_d          = 1'b0;
                    w_shift            = 1'b1;
                end else if (r_cnt != TOTAL_CNT) begin
                    w_cfg_d          = r_cfg >> 1;
                    w_cfg_d[TOTAL-1] = r_bit;
                    w_cnt_d          = w_cnt_inc;
                    w_valid_d        = (w_cnt_inc == TOTAL_CNT);
                    w_shift          = 1'b1;
                end else begin
                    w_ovf_d = 1'b1;
                end
            end
        end
    end

    // Session state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg   <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
            r_armed <= 1'b0;
        end else if (!w_rst_rel) begin
            r_cfg   <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_cfg   <= w_cfg_d;
            r_cnt   <= w_cnt_d;
            r_valid <= w_valid_d;
            r_ovf   <= w_ovf_d;
            r_armed <= w_armed_d;
        end
    end

`ifdef CFG_READBACK_EN
    logic r_sdo;

    // Readback: present the bit pushed out of cfg[0] on every shifting commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sdo <= 1'b0;
        end else if (!w_rst_rel) begin
            r_sdo <= 1'b0;
        end else if (w_shift) begin
            r_sdo <= r_cfg[0];
        end
    end

    assign sdo_o = r_sdo;
`else
    logic w_unused_shift;

    assign w_unused_shift = w_shift;
    assign sdo_o          = 1'b0;
`endif

    assign cfg_o       = r_cfg;
    assign cfg_valid_o = r_valid;
    assign bit_cnt_o   = r_cnt;
    assign err_ovf_o   = r_ovf;

endmodule

// File: tb/tb_rsnn_cfg_loader.sv
// tb_rsnn_cfg_loader: self-checking bench for rsnn_cfg_loader (default parameters).
// The reference model keeps the bits of the current session in a queue and derives the
// expected configuration bus, count, valid, overflow and readback bit from it.
module tb_rsnn_cfg_loader;

    localparam int N_LAYERS = 3;
    localparam int N_PARAM  = 4;
    localparam int N_WGT    = 9;
    localparam int WORD_W   = 8;
    localparam int MIN_HOLD = 3;
    localparam int N_WORDS  = N_LAYERS * (N_PARAM + N_WGT);
    localparam int TOTAL    = N_WORDS * WORD_W;
    localparam int CW       = $clog2(TOTAL + 1);

    logic             clk     = 1'b0;
    logic             rst_n   = 1'b0;
    logic             ena     = 1'b0;
    logic             load_i  = 1'b0;
    logic             sdata_i = 1'b0;
    logic             run_i   = 1'b0;
    logic [TOTAL-1:0] cfg_o;
    logic             cfg_valid_o;
    logic [CW-1:0]    bit_cnt_o;
    logic             err_ovf_o;
    logic             sdo_o;

    rsnn_cfg_loader #(
        .N_LAYERS (N_LAYERS),
        .N_PARAM  (N_PARAM),
        .N_WGT    (N_WGT),
        .WORD_W   (WORD_W),
        .MIN_HOLD (MIN_HOLD)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .load_i      (load_i),
        .sdata_i     (sdata_i),
        .run_i       (run_i),
        .cfg_o       (cfg_o),
        .cfg_valid_o (cfg_valid_o),
        .bit_cnt_o   (bit_cnt_o),
        .err_ovf_o   (err_ovf_o),
        .sdo_o       (sdo_o)
    );

    always #5 clk = ~clk;

    // Reference model state.
    bit m_q[$];
    bit m_ovf;
    bit m_armed;
    bit m_sdo;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int   hold;
        logic b;
        int   delta;
    } glitch_t;

    glitch_t gv[6];
    int      exp_cnt;
    int      op;
    int      h;
    int      nstr;
    logic    rb;

    function automatic logic [TOTAL-1:0] m_cfg();
        logic [TOTAL-1:0] v;
        int n;
        v = '0;
        n = m_q.size();
        // Oldest bit of the session sits lowest; the newest bit is always at the MSB.
        for (int i = 0; i < n; i++) v[TOTAL-n+i] = m_q[i];
        return v;
    endfunction

    task automatic m_reset();
        m_q.delete();
        m_ovf   = 1'b0;
        m_armed = 1'b0;
        m_sdo   = 1'b0;
    endtask

    task automatic m_commit(input logic b);
        if (m_armed) begin
            m_sdo = (m_q.size() == TOTAL) ? m_q[0] : 1'b0;
            m_q.delete();
            m_q.push_back(b);
            m_ovf   = 1'b0;
            m_armed = 1'b0;
        end else if (m_q.size() < TOTAL) begin
            m_sdo = (m_q.size() == TOTAL) ? m_q[0] : 1'b0;
            m_q.push_back(b);
        end else begin
            m_ovf = 1'b1;
        end
    endtask

    task automatic chk(input string name, input logic [TOTAL-1:0] act,
                       input logic [TOTAL-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic exp_sdo;
`ifdef CFG_READBACK_EN
        exp_sdo = m_sdo;
`else
        exp_sdo = 1'b0;
`endif
        chk({tag, " cfg"}, cfg_o, m_cfg());
        chk({tag, " valid"}, TOTAL'(cfg_valid_o), TOTAL'(m_q.size() == TOTAL));
        chk({tag, " cnt"}, TOTAL'(bit_cnt_o), TOTAL'(m_q.size()));
        chk({tag, " ovf"}, TOTAL'(err_ovf_o), TOTAL'(m_ovf));
        chk({tag, " sdo"}, TOTAL'(sdo_o), TOTAL'(exp_sdo));
    endtask

    // One strobe: load_i high for hi clocks, then low for lo clocks.
    task automatic strobe(input logic b, input int hi, input int lo);
        @(posedge clk);
        #1;
        load_i  = 1'b1;
        sdata_i = b;
        repeat (hi) @(posedge clk);
        #1;
        load_i = 1'b0;
        repeat (lo) @(posedge clk);
        #1;
    endtask

    // Let any pending commit land, then sample between edges.
    task automatic settle();
        repeat (3) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n   = 1'b0;
        load_i  = 1'b0;
        sdata_i = 1'b0;
        run_i   = 1'b0;
        ena     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        m_reset();
    endtask

    task automatic run_window(input int n, input logic en);
        @(posedge clk);
        #1;
        ena   = en;
        run_i = 1'b1;
        for (int i = 0; i < n; i++) strobe(1'($urandom), 5, 2);
        repeat (2) @(posedge clk);
        #1;
        run_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        ena = 1'b1;
        if (en && m_q.size() != 0) m_armed = 1'b1;
        settle();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        gv[0] = '{hold: 2, b: 1'b1, delta: 0};
        gv[1] = '{hold: 3, b: 1'b1, delta: 1};
        gv[2] = '{hold: 1, b: 1'b1, delta: 0};
        gv[3] = '{hold: 4, b: 1'b0, delta: 1};
        gv[4] = '{hold: 2, b: 1'b0, delta: 0};
        gv[5] = '{hold: 6, b: 1'b1, delta: 1};

        // Reset with random pin activity: everything must stay at zero.
        m_reset();
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            load_i  = 1'($urandom);
            sdata_i = 1'($urandom);
            run_i   = 1'($urandom);
            ena     = 1'($urandom);
        end
        @(negedge clk);
        chk("rst cfg", cfg_o, '0);
        chk("rst valid", TOTAL'(cfg_valid_o), '0);
        chk("rst cnt", TOTAL'(bit_cnt_o), '0);
        chk("rst ovf", TOTAL'(err_ovf_o), '0);
        chk("rst sdo", TOTAL'(sdo_o), '0);
        @(posedge clk);
        #1;
        load_i  = 1'b0;
        sdata_i = 1'b0;
        run_i   = 1'b0;
        ena     = 1'b1;
        rst_n   = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("post-rst cnt", TOTAL'(bit_cnt_o), '0);
        check_all("post-rst");

        // Glitch filtering table: strobes shorter than MIN_HOLD are dropped.
        exp_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            strobe(gv[i].b, gv[i].hold, 2);
            settle();
            exp_cnt += gv[i].delta;
            if (gv[i].delta != 0) begin
                m_commit(gv[i].b);
                chk("glitch msb", TOTAL'(cfg_o[TOTAL-1]), TOTAL'(gv[i].b));
            end
            chk("glitch cnt", TOTAL'(bit_cnt_o), TOTAL'(exp_cnt));
            check_all("glitch");
        end

        // Latency: cfg updates 3 clocks after load_i falls.
        @(posedge clk);
        #1;
        load_i  = 1'b1;
        sdata_i = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        load_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("lat +2 cnt", TOTAL'(bit_cnt_o), TOTAL'(exp_cnt));
        @(posedge clk);
        @(negedge clk);
        chk("lat +3 cnt", TOTAL'(bit_cnt_o), TOTAL'(exp_cnt + 1));
        m_commit(1'b1);
        check_all("lat");

        // Full load of words k+1, LSB first.
        do_reset();
        for (int k = 0; k < N_WORDS; k++) begin
            for (int j = 0; j < WORD_W; j++) begin
                strobe(1'((k + 1) >> j), 5, 2);
                m_commit(1'((k + 1) >> j));
                if (k * WORD_W + j == TOTAL - 2) begin
                    settle();
                    chk("pre-full valid", TOTAL'(cfg_valid_o), '0);
                end
            end
        end
        settle();
        chk("full valid", TOTAL'(cfg_valid_o), TOTAL'(1));
        chk("full word0", TOTAL'(cfg_o[7:0]), TOTAL'(8'h01));
        chk("full word38", TOTAL'(cfg_o[TOTAL-1 -: 8]), TOTAL'(8'h27));
        chk("full ovf", TOTAL'(err_ovf_o), '0);
        check_all("full");

        // Overflow: one dummy strobe past TOTAL.
        strobe(1'b1, 5, 2);
        m_commit(1'b1);
        settle();
        chk("ovf flag", TOTAL'(err_ovf_o), TOTAL'(1));
        check_all("ovf");

        // Run lockout for ~200 clocks with strobes, then a new session.
        run_window(25, 1'b1);
        check_all("run");
        strobe(1'b1, 5, 2);
        m_commit(1'b1);
        settle();
        chk("resess cnt", TOTAL'(bit_cnt_o), TOTAL'(1));
        chk("resess valid", TOTAL'(cfg_valid_o), '0);
        chk("resess ovf", TOTAL'(err_ovf_o), '0);
        chk("resess msb", TOTAL'(cfg_o[TOTAL-1]), TOTAL'(1));
        check_all("resess");

        // run_s rising in the commit cycle: run wins and the bit is dropped.
        strobe(1'b0, 5, 2);
        m_commit(1'b0);
        settle();
        @(posedge clk);
        #1;
        load_i  = 1'b1;
        sdata_i = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        load_i = 1'b0;
        run_i  = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        run_i = 1'b0;
        m_armed = 1'b1;
        settle();
        chk("race cnt", TOTAL'(bit_cnt_o), TOTAL'(2));
        check_all("race");
        strobe(1'b0, 5, 2);
        m_commit(1'b0);
        settle();
        chk("race resess cnt", TOTAL'(bit_cnt_o), TOTAL'(1));
        check_all("race resess");

        // ena=0 freezes loading.
        @(posedge clk);
        #1;
        ena = 1'b0;
        strobe(1'b1, 5, 2);
        settle();
        @(posedge clk);
        #1;
        ena = 1'b1;
        check_all("ena off");

        // Mid-load reset after 100 bits.
        do_reset();
        for (int i = 0; i < 100; i++) begin
            rb = 1'($urandom);
            strobe(rb, 5, 2);
            m_commit(rb);
        end
        settle();
        check_all("mid100");
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst cfg", cfg_o, '0);
        chk("midrst cnt", TOTAL'(bit_cnt_o), '0);
        chk("midrst valid", TOTAL'(cfg_valid_o), '0);
        m_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        strobe(1'b1, 5, 2);
        m_commit(1'b1);
        settle();
        chk("midrst next cnt", TOTAL'(bit_cnt_o), TOTAL'(1));
        check_all("midrst next");

        // Randomized operations against the model.
        for (int i = 0; i < 80; i++) begin
            op = $urandom_range(0, 9);
            if (op <= 5) begin
                h  = $urandom_range(1, 6);
                rb = 1'($urandom);
                strobe(rb, h, 2);
                settle();
                if (h >= MIN_HOLD) m_commit(rb);
            end else if (op <= 7) begin
                nstr = $urandom_range(1, 3);
                run_window(nstr, 1'b1);
            end else if (op == 8) begin
                @(posedge clk);
                #1;
                ena = 1'b0;
                strobe(1'($urandom), 5, 2);
                settle();
                @(posedge clk);
                #1;
                ena = 1'b1;
                @(negedge clk);
            end else begin
                nstr = $urandom_range(1, 2);
                run_window(nstr, 1'b0);
            end
            check_all("rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
